dvi_rx_timing_gen: RTL and testbench

Parametrised, synthesisable stand-in for the DVI receiver front end. It produces a complete RGB video stream (pixel clock, syncs, data enable, pixel data) from one system clock, with programmable porch/sync timing, sync polarities, a selectable test pattern and a modelled PLL phase search/lock sequence. It feeds the matrix-scaling path in place of the real TMDS decoder, for board bring-up and for benches.

---
 rtl/dvi_rx_timing_gen.sv | 211 +++++++++++++++++++++
 tb/tb_dvi_rx_timing_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_rx_timing_gen.sv
// Synthetic DVI receiver front end: modelled PLL lock, video timing and test patterns.
// Define DVI_RX_TIMING_LOCK_SWEEP_EN to model the PLL phase search; otherwise lock follows reset directly.
module dvi_rx_timing_gen #(
    parameter int unsigned H_ACTIVE     = 128,
    parameter int unsigned H_FP         = 4,
    parameter int unsigned H_SYNC       = 4,
    parameter int unsigned H_BP         = 8,
    parameter int unsigned V_ACTIVE     = 32,
    parameter int unsigned V_FP         = 2,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 4,
    parameter bit          HS_POL       = 1'b1,
    parameter bit          VS_POL       = 1'b1,
    parameter int unsigned PIX_DIV      = 2,
    parameter int unsigned SWEEP_CYCLES = 16,
    parameter logic [3:0]  LOCK_PHASE   = 4'd9,
    parameter logic [23:0] SOLID_RGB    = 24'hFF0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] I_pattern_sel,
    input  logic       I_relock,
    output logic [3:0] O_pll_phase,
    output logic       O_pll_phase_lock,
    output logic       O_rgb_clk,
    output logic       O_rgb_vs,
    output logic       O_rgb_hs,
    output logic       O_rgb_de,
    output logic [7:0] O_rgb_r,
    output logic [7:0] O_rgb_g,
    output logic [7:0] O_rgb_b
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int unsigned VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
    localparam int unsigned DW = $clog2(PIX_DIV);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] BAR_W   = HW'(H_ACTIVE / 8);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(PIX_DIV / 2);
    localparam logic [15:0]   COL_MOD  = 16'(H_ACTIVE);

`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
    localparam int unsigned SW = ($clog2(SWEEP_CYCLES) > 0) ? $clog2(SWEEP_CYCLES) : 1;
    localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_CYCLES - 1);
    localparam logic [3:0]    RESET_PHASE = 4'd0;
    logic [SW-1:0] sweep_cnt;
`else
    localparam logic [3:0]    RESET_PHASE = LOCK_PHASE;
`endif

    typedef enum logic [1:0] {ST_RESET, ST_SEARCH, ST_LOCKED} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [2:0]    pat_q;
    logic [15:0]   frame_cnt;
    logic          first_done;

    logic          frame_start;
    logic [2:0]    pat_eff;
    logic [15:0]   fc_eff;
    logic          de_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic [2:0]    bar_idx;
    logic [23:0]   rgb_nxt;

    // The frame-start pixel already uses the newly latched pattern and frame count.
    always_comb begin
        frame_start = (state == ST_LOCKED) && (div_cnt == '0) && (h_cnt == '0) && (v_cnt == '0);
        pat_eff     = frame_start ? I_pattern_sel : pat_q;
        fc_eff      = (frame_start && first_done) ? frame_cnt + 16'd1 : frame_cnt;
        de_nxt      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_nxt      = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_POL : !HS_POL;
        vs_nxt      = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_POL : !VS_POL;
        bar_idx     = 3'(h_cnt / BAR_W);
        rgb_nxt     = '0;
        if (de_nxt) begin
            case (pat_eff)
                3'd0: rgb_nxt = SOLID_RGB;
                3'd1: begin
                    case (bar_idx)
                        3'd0:    rgb_nxt = 24'hFFFFFF;
                        3'd1:    rgb_nxt = 24'hFFFF00;
                        3'd2:    rgb_nxt = 24'h00FFFF;
                        3'd3:    rgb_nxt = 24'h00FF00;
                        3'd4:    rgb_nxt = 24'hFF00FF;
                        3'd5:    rgb_nxt = 24'hFF0000;
                        3'd6:    rgb_nxt = 24'h0000FF;
                        default: rgb_nxt = 24'h000000;
                    endcase
                end
                3'd2: rgb_nxt = {3{h_cnt[7:0]}};
                3'd3: rgb_nxt = (h_cnt[3] ^ v_cnt[3]) ? '1 : '0;
                3'd4: rgb_nxt = (16'(h_cnt) == (fc_eff % COL_MOD)) ? '1 : '0;
                3'd5: rgb_nxt = {h_cnt[7:0], v_cnt[7:0], fc_eff[7:0]};
                default: rgb_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_RESET;
            O_pll_phase      <= RESET_PHASE;
            O_pll_phase_lock <= 1'b0;
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
            sweep_cnt        <= '0;
`endif
            div_cnt          <= '0;
            h_cnt            <= '0;
            v_cnt            <= '0;
            pat_q            <= '0;
            frame_cnt        <= '0;
            first_done       <= 1'b0;
            O_rgb_clk        <= 1'b0;
            O_rgb_de         <= 1'b0;
            O_rgb_hs         <= !HS_POL;
            O_rgb_vs         <= !VS_POL;
            {O_rgb_r, O_rgb_g, O_rgb_b} <= '0;
        end else if (I_relock) begin
            // Relock takes priority over everything, including a coincident frame start.
            div_cnt    <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_cnt  <= '0;
            first_done <= 1'b0;
            O_rgb_clk  <= 1'b0;
            O_rgb_de   <= 1'b0;
            O_rgb_hs   <= !HS_POL;
            O_rgb_vs   <= !VS_POL;
            {O_rgb_r, O_rgb_g, O_rgb_b} <= '0;
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
            state            <= ST_SEARCH;
            O_pll_phase      <= '0;
            O_pll_phase_lock <= 1'b0;
            sweep_cnt        <= '0;
`else
            state            <= ST_LOCKED;
            O_pll_phase_lock <= 1'b1;
`endif
        end else begin
            case (state)
                ST_RESET: begin
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
                    state       <= ST_SEARCH;
                    O_pll_phase <= '0;
                    sweep_cnt   <= '0;
`else
                    state            <= ST_LOCKED;
                    O_pll_phase_lock <= 1'b1;
`endif
                end
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
                ST_SEARCH: begin
                    if (sweep_cnt == SWEEP_LAST) begin
                        sweep_cnt <= '0;
                        if (O_pll_phase == LOCK_PHASE) begin
                            state            <= ST_LOCKED;
                            O_pll_phase_lock <= 1'b1;
                        end else begin
                            O_pll_phase <= O_pll_phase + 4'd1;
                        end
                    end else begin
                        sweep_cnt <= sweep_cnt + SW'(1);
                    end
                end
`endif
                ST_LOCKED: begin
                    O_rgb_clk <= (div_cnt < DIV_HALF);
                    if (div_cnt == '0) begin
                        O_rgb_de <= de_nxt;
                        O_rgb_hs <= hs_nxt;
                        O_rgb_vs <= vs_nxt;
                        {O_rgb_r, O_rgb_g, O_rgb_b} <= rgb_nxt;
                        if (frame_start) begin
                            pat_q      <= pat_eff;
                            frame_cnt  <= fc_eff;
                            first_done <= 1'b1;
                        end
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (h_cnt == H_LAST) begin
                            h_cnt <= '0;
                            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                        end else begin
                            h_cnt <= h_cnt + HW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_dvi_rx_timing_gen.sv
// Directed bench for dvi_rx_timing_gen: lock sequence, frame timing, patterns, relock and async reset.
module tb_dvi_rx_timing_gen;
    localparam int HT = 24;
    localparam int VT = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sel;
    logic       relock;
    logic [3:0] phase;
    logic       lock, rgb_clk, vs, hs, de;
    logic [7:0] r, g, b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvi_rx_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .PIX_DIV(2), .SWEEP_CYCLES(4), .LOCK_PHASE(4'd9), .SOLID_RGB(24'hFF0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .I_pattern_sel(sel), .I_relock(relock),
        .O_pll_phase(phase), .O_pll_phase_lock(lock), .O_rgb_clk(rgb_clk),
        .O_rgb_vs(vs), .O_rgb_hs(hs), .O_rgb_de(de),
        .O_rgb_r(r), .O_rgb_g(g), .O_rgb_b(b)
    );

    typedef struct {
        int          f;
        int          h;
        int          v;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;

    vec_t        vecs[$];
    logic [26:0] cap [0:9][0:VT-1][0:HT-1];

    function automatic vec_t mk(input int f, input int h, input int v,
                                input logic e, input logic hh, input logic vv, input logic [23:0] c);
        vec_t t;
        t.f = f; t.h = h; t.v = v; t.de = e; t.hs = hh; t.vs = vv; t.rgb = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_blank(input string tag);
        chk({tag, "_rgb_clk"}, {31'd0, rgb_clk}, 32'd0);
        chk({tag, "_de"}, {31'd0, de}, 32'd0);
        chk({tag, "_hs"}, {31'd0, hs}, 32'd1);
        chk({tag, "_vs"}, {31'd0, vs}, 32'd0);
        chk({tag, "_rgb"}, {8'd0, r, g, b}, 32'd0);
    endtask

    // Counts edges until lock; phase during search must step every 4 clocks.
    task automatic wait_lock(input int off, output int n, output int bad);
        n = 0;
        bad = 0;
        while (lock !== 1'b1 && n < 200) begin
            step();
            n++;
            if (lock !== 1'b1 && phase !== 4'((n + off) / 4)) bad++;
        end
    endtask

    task automatic capture_frame(input int f, input logic [2:0] next_sel);
        int bad;
        logic [26:0] s;
        bad = 0;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                step();
                if (rgb_clk !== 1'b1) bad++;
                s = {de, hs, vs, r, g, b};
                cap[f][v][h] = s;
                if (f == 1 && v == 3 && h == 5) sel = 3'd5;
                step();
                if (rgb_clk !== 1'b0 || {de, hs, vs, r, g, b} !== s) bad++;
                if (v == VT - 1 && h == HT - 1) sel = next_sel;
            end
        end
        chk($sformatf("frame%0d_pixclk_hold", f), bad, 0);
    endtask

    initial begin
        int n;
        int bad;
        logic [2:0] pats [0:8];

        pats[0] = 3'd1; pats[1] = 3'd2; pats[2] = 3'd5; pats[3] = 3'd3; pats[4] = 3'd4;
        pats[5] = 3'd0; pats[6] = 3'd6; pats[7] = 3'd5; pats[8] = 3'd5;

        // bars (H_ACTIVE 16 -> 2 px per bar), syncs and blanking
        vecs.push_back(mk(0,  0, 0, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(0,  1, 2, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(0,  2, 0, 1, 1, 0, 24'hFFFF00));
        vecs.push_back(mk(0,  5, 3, 1, 1, 0, 24'h00FFFF));
        vecs.push_back(mk(0,  7, 0, 1, 1, 0, 24'h00FF00));
        vecs.push_back(mk(0,  9, 1, 1, 1, 0, 24'hFF00FF));
        vecs.push_back(mk(0, 10, 7, 1, 1, 0, 24'hFF0000));
        vecs.push_back(mk(0, 13, 0, 1, 1, 0, 24'h0000FF));
        vecs.push_back(mk(0, 15, 7, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(0, 16, 0, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(0, 17, 0, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(0, 18, 0, 0, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 19, 5, 0, 0, 0, 24'h000000));
        vecs.push_back(mk(0, 20, 0, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(0,  3, 8, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(0,  0, 9, 0, 1, 1, 24'h000000));
        vecs.push_back(mk(0, 18, 9, 0, 0, 1, 24'h000000));
        vecs.push_back(mk(0, 23, 10, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(0,  4, 11, 0, 1, 0, 24'h000000));
        // ramp; selection switched to 5 mid-frame must be ignored
        vecs.push_back(mk(1,  7, 0, 1, 1, 0, 24'h070707));
        vecs.push_back(mk(1, 12, 6, 1, 1, 0, 24'h0C0C0C));
        vecs.push_back(mk(1, 15, 7, 1, 1, 0, 24'h0F0F0F));
        vecs.push_back(mk(1, 16, 7, 0, 1, 0, 24'h000000));
        // r=h g=v b=frame_cnt (third frame after lock -> 2)
        vecs.push_back(mk(2,  3, 5, 1, 1, 0, 24'h030502));
        vecs.push_back(mk(2, 15, 7, 1, 1, 0, 24'h0F0702));
        vecs.push_back(mk(2,  0, 0, 1, 1, 0, 24'h000002));
        // checkerboard: v < 8 so only h[3] matters
        vecs.push_back(mk(3,  7, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(3,  8, 0, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(3, 15, 7, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(3,  0, 4, 1, 1, 0, 24'h000000));
        // moving column at frame_cnt 4
        vecs.push_back(mk(4,  4, 0, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(4,  4, 7, 1, 1, 0, 24'hFFFFFF));
        vecs.push_back(mk(4,  3, 0, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(4,  5, 2, 1, 1, 0, 24'h000000));
        vecs.push_back(mk(5,  0, 0, 1, 1, 0, 24'hFF0000));
        vecs.push_back(mk(5, 15, 7, 1, 1, 0, 24'hFF0000));
        vecs.push_back(mk(5, 20, 3, 0, 1, 0, 24'h000000));
        vecs.push_back(mk(6,  1, 1, 1, 1, 0, 24'h000000));
        // after relock frame_cnt restarts at 0
        vecs.push_back(mk(7,  3, 2, 1, 1, 0, 24'h030200));
        vecs.push_back(mk(8,  3, 2, 1, 1, 0, 24'h030201));

        sel = 3'd1;
        relock = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        chk("reset_lock", {31'd0, lock}, 32'd0);
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
        chk("reset_phase", {28'd0, phase}, 32'd0);
`endif

        rst_n = 1'b1;
        wait_lock(-1, n, bad);
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
        chk("lock_latency", n, 41);
        chk("search_phase_steps", bad, 0);
`else
        chk("lock_latency", n, 1);
`endif
        chk("lock_phase", {28'd0, phase}, 32'd9);
        chk("lock_edge_blank_de", {31'd0, de}, 32'd0);

        for (int f = 0; f < 7; f++) capture_frame(f, pats[f + 1]);
`ifndef DVI_RX_TIMING_LOCK_SWEEP_EN
        chk("steady_phase", {28'd0, phase}, 32'd9);
        chk("steady_lock", {31'd0, lock}, 32'd1);
`endif

        // relock mid-line
        repeat (10) step();
        chk("pre_relock_de", {31'd0, de}, 32'd1);
        relock = 1'b1;
        step();
        relock = 1'b0;
        check_blank("relock");
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
        chk("relock_lock", {31'd0, lock}, 32'd0);
        chk("relock_phase", {28'd0, phase}, 32'd0);
        wait_lock(0, n, bad);
        chk("relock_latency", n, 40);
        chk("relock_phase_steps", bad, 0);
`else
        chk("relock_lock_held", {31'd0, lock}, 32'd1);
        chk("relock_phase_held", {28'd0, phase}, 32'd9);
`endif
        capture_frame(7, pats[8]);
        capture_frame(8, pats[8]);

        foreach (vecs[i]) begin
            chk($sformatf("vec%0d_f%0d_h%0d_v%0d", i, vecs[i].f, vecs[i].h, vecs[i].v),
                {5'd0, cap[vecs[i].f][vecs[i].v][vecs[i].h]},
                {5'd0, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].rgb});
        end

        // relock exactly on the frame-start edge: no pixel may be emitted
        relock = 1'b1;
        step();
        relock = 1'b0;
        chk("fs_relock_rgb_clk", {31'd0, rgb_clk}, 32'd0);
        chk("fs_relock_de", {31'd0, de}, 32'd0);
`ifdef DVI_RX_TIMING_LOCK_SWEEP_EN
        wait_lock(0, n, bad);
        chk("fs_relock_latency", n, 40);
`endif
        step();
        chk("restart_pix0_clk", {31'd0, rgb_clk}, 32'd1);
        chk("restart_pix0_de", {31'd0, de}, 32'd1);
        repeat (2) step();
        chk("restart_pix1_rgb", {8'd0, r, g, b}, 32'h010000);

        // asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");
        chk("async_reset_lock", {31'd0, lock}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
